// File: rtl/rv_mem_arbiter.sv
// Two-master arbiter sharing one registered memory bus port between instruction fetch and LSU.
// Data wins ties, limited by a streak counter; supports fetch flush dropping and a bus timeout.
module rv_mem_arbiter #(
  parameter int unsigned DATA_STREAK_MAX = 4,
  parameter int unsigned TIMEOUT_CYCLES  = 255
) (
  input  logic        i_clk,
  input  logic        i_reset,

  input  logic        i_fetch_cyc,
  input  logic [31:0] i_fetch_addr,
  input  logic        i_fetch_flush,
  output logic        o_fetch_ack,
  output logic        o_fetch_err,
  output logic [31:0] o_fetch_rdata,

  input  logic        i_data_cyc,
  input  logic        i_data_we,
  input  logic [3:0]  i_data_sel,
  input  logic [31:0] i_data_addr,
  input  logic [31:0] i_data_wdata,
  output logic        o_data_ack,
  output logic        o_data_err,
  output logic [31:0] o_data_rdata,

  output logic        o_mem_cyc,
  output logic        o_mem_we,
  output logic [3:0]  o_mem_sel,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  input  logic        i_mem_ack,
  input  logic [31:0] i_mem_rdata
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] BUSY_F = 2'd1;
  localparam logic [1:0] BUSY_D = 2'd2;

  localparam int unsigned SW = (DATA_STREAK_MAX < 1) ? 1 : $clog2(DATA_STREAK_MAX + 1);
  localparam int unsigned TW = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  logic [1:0]    state_q, state_d;
  logic [SW-1:0] streak_q, streak_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          drop_q, drop_d;
  logic          mem_cyc_q, mem_cyc_d;
  logic          mem_we_q, mem_we_d;
  logic [3:0]    mem_sel_q, mem_sel_d;
  logic [31:0]   mem_addr_q, mem_addr_d;
  logic [31:0]   mem_wdata_q, mem_wdata_d;

  logic fetch_req, streak_full, grant_data, grant_fetch;
  logic busy, timeout_hit, done, fetch_drop;
  logic in_busy_f, in_busy_d;

  assign fetch_req   = i_fetch_cyc & ~i_fetch_flush;
  assign streak_full = (streak_q == SW'(DATA_STREAK_MAX));
  assign grant_data  = (state_q == IDLE) & i_data_cyc & ~(fetch_req & streak_full);
  assign grant_fetch = (state_q == IDLE) & fetch_req & ~grant_data;

  assign busy      = (state_q == BUSY_F) | (state_q == BUSY_D);
  assign in_busy_f = (state_q == BUSY_F);
  assign in_busy_d = (state_q == BUSY_D);

  // The counter holds the number of completed BUSY cycles, so the cycle that would bring it to
  // TIMEOUT_CYCLES is the last one; an ack in that same cycle takes priority.
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && busy && !i_mem_ack &&
                       (tmo_q == TW'(TIMEOUT_CYCLES - 1));
  assign done        = busy & (i_mem_ack | timeout_hit);
  assign fetch_drop  = drop_q | i_fetch_flush;

  always_comb begin
    state_d     = state_q;
    streak_d    = streak_q;
    tmo_d       = tmo_q;
    drop_d      = drop_q;
    mem_cyc_d   = mem_cyc_q;
    mem_we_d    = mem_we_q;
    mem_sel_d   = mem_sel_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    unique case (state_q)
      IDLE: begin
        tmo_d  = '0;
        drop_d = 1'b0;
        if (grant_data) begin
          state_d     = BUSY_D;
          mem_cyc_d   = 1'b1;
          mem_we_d    = i_data_we;
          mem_sel_d   = i_data_sel;
          mem_addr_d  = i_data_addr;
          mem_wdata_d = i_data_wdata;
          // A data grant with fetch waiting implies the streak is below its limit.
          streak_d    = fetch_req ? streak_q + SW'(1) : '0;
        end else if (grant_fetch) begin
          state_d     = BUSY_F;
          mem_cyc_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_sel_d   = 4'hF;
          mem_addr_d  = i_fetch_addr;
          mem_wdata_d = '0;
          streak_d    = '0;
        end
      end
      BUSY_F, BUSY_D: begin
        tmo_d = tmo_q + TW'(1);
        if (in_busy_f && i_fetch_flush) begin
          drop_d = 1'b1;
        end
        if (done) begin
          state_d   = IDLE;
          mem_cyc_d = 1'b0;
          drop_d    = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q     <= IDLE;
      streak_q    <= '0;
      tmo_q       <= '0;
      drop_q      <= 1'b0;
      mem_cyc_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_sel_q   <= 4'h0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      streak_q    <= streak_d;
      tmo_q       <= tmo_d;
      drop_q      <= drop_d;
      mem_cyc_q   <= mem_cyc_d;
      mem_we_q    <= mem_we_d;
      mem_sel_q   <= mem_sel_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign o_mem_cyc   = mem_cyc_q;
  assign o_mem_we    = mem_we_q;
  assign o_mem_sel   = mem_sel_q;
  assign o_mem_addr  = mem_addr_q;
  assign o_mem_wdata = mem_wdata_q;

  // Responses are combinational from the bus ack; reset masks a stray ack in the reset cycle.
  assign o_fetch_ack   = ~i_reset & in_busy_f & i_mem_ack & ~fetch_drop;
  assign o_fetch_err   = ~i_reset & in_busy_f & timeout_hit & ~fetch_drop;
  assign o_data_ack    = ~i_reset & in_busy_d & i_mem_ack;
  assign o_data_err    = ~i_reset & in_busy_d & timeout_hit;
  assign o_fetch_rdata = o_fetch_ack ? i_mem_rdata : 32'h0;
  assign o_data_rdata  = o_data_ack ? i_mem_rdata : 32'h0;

endmodule

// File: tb/tb_rv_mem_arbiter.sv
// Self-checking bench for rv_mem_arbiter: vector table, directed corner sequences and a
// randomized transaction-level run against a reference model of the arbitration rules.
module tb_rv_mem_arbiter;

  localparam int STREAK = 4;
  localparam int TMO    = 8;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_fetch_cyc, i_fetch_flush;
  logic [31:0] i_fetch_addr;
  logic        o_fetch_ack, o_fetch_err;
  logic [31:0] o_fetch_rdata;
  logic        i_data_cyc, i_data_we;
  logic [3:0]  i_data_sel;
  logic [31:0] i_data_addr, i_data_wdata;
  logic        o_data_ack, o_data_err;
  logic [31:0] o_data_rdata;
  logic        o_mem_cyc, o_mem_we;
  logic [3:0]  o_mem_sel;
  logic [31:0] o_mem_addr, o_mem_wdata;
  logic        i_mem_ack;
  logic [31:0] i_mem_rdata;

  always #5 i_clk = ~i_clk;

  rv_mem_arbiter #(.DATA_STREAK_MAX(STREAK), .TIMEOUT_CYCLES(TMO)) dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_fetch_cyc(i_fetch_cyc), .i_fetch_addr(i_fetch_addr), .i_fetch_flush(i_fetch_flush),
    .o_fetch_ack(o_fetch_ack), .o_fetch_err(o_fetch_err), .o_fetch_rdata(o_fetch_rdata),
    .i_data_cyc(i_data_cyc), .i_data_we(i_data_we), .i_data_sel(i_data_sel),
    .i_data_addr(i_data_addr), .i_data_wdata(i_data_wdata),
    .o_data_ack(o_data_ack), .o_data_err(o_data_err), .o_data_rdata(o_data_rdata),
    .o_mem_cyc(o_mem_cyc), .o_mem_we(o_mem_we), .o_mem_sel(o_mem_sel),
    .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
    .i_mem_ack(i_mem_ack), .i_mem_rdata(i_mem_rdata)
  );

  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle_inputs();
    i_fetch_cyc = 1'b0; i_fetch_flush = 1'b0; i_fetch_addr = 32'h0;
    i_data_cyc = 1'b0; i_data_we = 1'b0; i_data_sel = 4'h0;
    i_data_addr = 32'h0; i_data_wdata = 32'h0;
    i_mem_ack = 1'b0; i_mem_rdata = 32'h0;
  endtask

  task automatic do_reset();
    idle_inputs();
    i_reset = 1'b1;
    step();
    i_reset = 1'b0;
  endtask

  function automatic logic [4:0] resp();
    return {o_mem_cyc, o_fetch_ack, o_fetch_err, o_data_ack, o_data_err};
  endfunction

  // Waits for a bus cycle, acks it in its first cycle and reports its address ('1 if none).
  task automatic serve(output logic [31:0] addr);
    addr = '1;
    for (int k = 0; k < 20; k++) begin
      @(negedge i_clk);
      if (o_mem_cyc) begin
        addr = o_mem_addr;
        i_mem_ack = 1'b1;
        step();
        i_mem_ack = 1'b0;
        return;
      end
      step();
    end
  endtask

  typedef struct {
    logic        fcyc, flush, dcyc, dwe;
    logic [3:0]  dsel;
    logic [31:0] faddr, daddr, wdata, rdata;
    logic        exp_cyc, exp_we;
    logic [3:0]  exp_sel;
    logic [31:0] exp_addr;
    logic        exp_fack, exp_dack;
  } vec_t;

  vec_t vt[8];

  initial begin
    logic [31:0] seen;
    logic [31:0] streak_exp[6];
    int busy_n, err_n, ack_n;

    #10000000;
    $display("FAIL watchdog: time limit reached, got %0d/%0d", pass_cnt, total_cnt);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] seen;
    logic [31:0] streak_exp[6];
    int          busy_n, err_n, ack_n;
    int          m_streak, owner, lat, flush_at, end_c;
    logic        fc, fl, dc, freq, timed_out, dropped, fack, ferr, dack, derr;
    logic [31:0] rd;

    vt[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 32'h100, 32'h0, 32'h0, 32'h13,
              1'b1, 1'b0, 4'hF, 32'h100, 1'b1, 1'b0};
    vt[1] = '{1'b0, 1'b0, 1'b1, 1'b1, 4'h3, 32'h0, 32'h2000, 32'hCAFE, 32'h0,
              1'b1, 1'b1, 4'h3, 32'h2000, 1'b0, 1'b1};
    vt[2] = '{1'b1, 1'b0, 1'b1, 1'b1, 4'h3, 32'h100, 32'h2000, 32'hCAFE, 32'h0,
              1'b1, 1'b1, 4'h3, 32'h2000, 1'b0, 1'b1};
    vt[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 32'h100, 32'h0, 32'h0, 32'h0,
              1'b0, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0};
    vt[4] = '{1'b1, 1'b1, 1'b1, 1'b0, 4'hC, 32'h100, 32'h3004, 32'h0, 32'hDEADBEEF,
              1'b1, 1'b0, 4'hC, 32'h3004, 1'b0, 1'b1};
    vt[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 4'h1, 32'h0, 32'h44, 32'h0, 32'h55,
              1'b1, 1'b0, 4'h1, 32'h44, 1'b0, 1'b1};
    vt[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0, 32'h0,
              1'b0, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0};
    vt[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 4'h5, 32'hFFFFFFFC, 32'h0, 32'h0, 32'hA5A5A5A5,
              1'b1, 1'b0, 4'hF, 32'hFFFFFFFC, 1'b1, 1'b0};

    // Reset state
    do_reset();
    @(negedge i_clk);
    check("rst_resp", {27'h0, resp()}, 32'h0);
    check("rst_we_sel", {27'h0, o_mem_we, o_mem_sel}, 32'h0);
    check("rst_addr", o_mem_addr, 32'h0);
    check("rst_wdata", o_mem_wdata, 32'h0);
    check("rst_rdata", o_fetch_rdata | o_data_rdata, 32'h0);

    // Vector table: one arbitration from IDLE, then a single-cycle ack
    for (int i = 0; i < 8; i++) begin
      do_reset();
      i_fetch_cyc = vt[i].fcyc; i_fetch_flush = vt[i].flush; i_fetch_addr = vt[i].faddr;
      i_data_cyc = vt[i].dcyc; i_data_we = vt[i].dwe; i_data_sel = vt[i].dsel;
      i_data_addr = vt[i].daddr; i_data_wdata = vt[i].wdata;
      step();
      i_fetch_cyc = 1'b0; i_data_cyc = 1'b0; i_fetch_flush = 1'b0;
      @(negedge i_clk);
      check($sformatf("vec%0d_cyc", i), {31'h0, o_mem_cyc}, {31'h0, vt[i].exp_cyc});
      if (vt[i].exp_cyc) begin
        check($sformatf("vec%0d_we_sel", i), {27'h0, o_mem_we, o_mem_sel},
              {27'h0, vt[i].exp_we, vt[i].exp_sel});
        check($sformatf("vec%0d_addr", i), o_mem_addr, vt[i].exp_addr);
        if (vt[i].exp_we) check($sformatf("vec%0d_wdata", i), o_mem_wdata, vt[i].wdata);
        i_mem_ack = 1'b1; i_mem_rdata = vt[i].rdata;
        #1;
        check($sformatf("vec%0d_acks", i), {30'h0, o_fetch_ack, o_data_ack},
              {30'h0, vt[i].exp_fack, vt[i].exp_dack});
        check($sformatf("vec%0d_frdata", i), o_fetch_rdata, vt[i].exp_fack ? vt[i].rdata : 32'h0);
        check($sformatf("vec%0d_drdata", i), o_data_rdata, vt[i].exp_dack ? vt[i].rdata : 32'h0);
        step();
        i_mem_ack = 1'b0;
      end
    end

    // Fetch with a two-cycle memory latency
    do_reset();
    i_fetch_cyc = 1'b1; i_fetch_addr = 32'h100;
    @(negedge i_clk);
    check("lat_idle_cyc", {31'h0, o_mem_cyc}, 32'h0);
    step();
    @(negedge i_clk);
    check("lat_bus", {o_mem_addr[27:0], o_mem_we, o_mem_sel[2:0]}, {28'h100, 1'b0, 3'h7});
    check("lat_noack", {27'h0, resp()}, 32'h10);
    step();
    i_mem_ack = 1'b1; i_mem_rdata = 32'h13;
    @(negedge i_clk);
    check("lat_ack", {27'h0, resp()}, 32'h18);
    check("lat_rdata", o_fetch_rdata, 32'h13);
    step();
    i_mem_ack = 1'b0; i_fetch_cyc = 1'b0;
    @(negedge i_clk);
    check("lat_done", {27'h0, resp()}, 32'h0);

    // Simultaneous requests: data first, one bubble, then fetch
    do_reset();
    i_fetch_cyc = 1'b1; i_fetch_addr = 32'h400;
    i_data_cyc = 1'b1; i_data_we = 1'b1; i_data_sel = 4'h3;
    i_data_addr = 32'h2000; i_data_wdata = 32'hCAFE;
    step();
    @(negedge i_clk);
    check("both_data_bus", {27'h0, o_mem_we, o_mem_sel}, 32'h13);
    check("both_data_wdata", o_mem_wdata, 32'hCAFE);
    i_mem_ack = 1'b1;
    #1;
    check("both_data_ack", {27'h0, resp()}, 32'h12);
    step();
    i_mem_ack = 1'b0; i_data_cyc = 1'b0;
    @(negedge i_clk);
    check("both_bubble", {31'h0, o_mem_cyc}, 32'h0);
    step();
    @(negedge i_clk);
    check("both_fetch_addr", o_mem_addr, 32'h400);
    check("both_fetch_bus", {27'h0, o_mem_cyc, o_mem_we, o_mem_sel[2:0]}, 32'h17);
    i_mem_ack = 1'b1;
    #1;
    check("both_fetch_ack", {27'h0, resp()}, 32'h18);
    step();
    i_mem_ack = 1'b0; i_fetch_cyc = 1'b0;

    // Data streak limit with a fetch pending
    streak_exp = '{32'hD000, 32'hD000, 32'hD000, 32'hD000, 32'hF000, 32'hD000};
    do_reset();
    i_data_cyc = 1'b1; i_data_addr = 32'hD000; i_data_sel = 4'hF;
    i_fetch_cyc = 1'b1; i_fetch_addr = 32'hF000;
    for (int g = 0; g < 6; g++) begin
      serve(seen);
      if (seen == 32'hF000) i_fetch_cyc = 1'b0;
      check($sformatf("streak_grant%0d", g), seen, streak_exp[g]);
    end
    idle_inputs();
    step();
    step();

    // Flush while the fetch is in flight, then refetch; flush coincident with ack
    do_reset();
    i_fetch_cyc = 1'b1; i_fetch_addr = 32'h100;
    step();
    step();
    i_fetch_flush = 1'b1;
    step();
    i_fetch_flush = 1'b0; i_fetch_addr = 32'h200;
    i_mem_ack = 1'b1; i_mem_rdata = 32'h13;
    @(negedge i_clk);
    check("flush_dropped", {27'h0, resp()}, 32'h10);
    check("flush_rdata", o_fetch_rdata, 32'h0);
    step();
    i_mem_ack = 1'b0;
    @(negedge i_clk);
    check("flush_idle", {31'h0, o_mem_cyc}, 32'h0);
    step();
    @(negedge i_clk);
    check("flush_refetch", {o_mem_addr[30:0], o_mem_cyc}, {31'h200, 1'b1});
    step();
    i_fetch_flush = 1'b1; i_mem_ack = 1'b1;
    @(negedge i_clk);
    check("flush_coincident", {27'h0, resp()}, 32'h10);
    step();
    idle_inputs();

    // Timeout on a data cycle, then ack landing on the timeout cycle
    do_reset();
    i_data_cyc = 1'b1; i_data_addr = 32'h3000;
    step();
    i_data_cyc = 1'b0;
    busy_n = 0; err_n = 0; ack_n = 0;
    for (int k = 0; k < 16; k++) begin
      @(negedge i_clk);
      if (o_mem_cyc) busy_n++;
      if (o_data_err) err_n++;
      if (o_data_ack) ack_n++;
      step();
    end
    check("tmo_busy_cycles", busy_n, TMO);
    check("tmo_err_pulses", err_n, 1);
    check("tmo_no_ack", ack_n, 0);
    i_data_cyc = 1'b1;
    step();
    i_data_cyc = 1'b0;
    @(negedge i_clk);
    check("tmo_regrant", {31'h0, o_mem_cyc}, 32'h1);
    for (int k = 1; k < TMO; k++) step();
    i_mem_ack = 1'b1;
    @(negedge i_clk);
    check("tmo_ack_wins", {27'h0, resp()}, 32'h12);
    step();
    i_mem_ack = 1'b0;
    @(negedge i_clk);
    check("tmo_ack_done", {31'h0, o_mem_cyc}, 32'h0);

    // Reset in BUSY_D, then a late ack
    do_reset();
    i_data_cyc = 1'b1; i_data_we = 1'b1; i_data_addr = 32'h5000;
    i_data_sel = 4'hF; i_data_wdata = 32'h1234;
    step();
    i_data_cyc = 1'b0;
    @(negedge i_clk);
    check("rstbusy_granted", {31'h0, o_mem_cyc}, 32'h1);
    step();
    i_reset = 1'b1;
    step();
    i_reset = 1'b0; i_mem_ack = 1'b1; i_mem_rdata = 32'h77;
    @(negedge i_clk);
    check("rstbusy_resp", {27'h0, resp()}, 32'h0);
    check("rstbusy_bus", {o_mem_addr[26:0], o_mem_we, o_mem_sel}, 32'h0);
    check("rstbusy_wdata", o_mem_wdata, 32'h0);
    check("rstbusy_rdata", o_data_rdata, 32'h0);
    step();
    idle_inputs();

    // Randomized transactions against the arbitration/response model
    do_reset();
    m_streak = 0;
    for (int it = 0; it < 200; it++) begin
      fc = 1'($urandom_range(0, 1));
      fl = ($urandom_range(0, 3) == 0);
      dc = 1'($urandom_range(0, 1));
      i_fetch_cyc = fc; i_fetch_flush = fl; i_fetch_addr = $urandom;
      i_data_cyc = dc; i_data_we = 1'($urandom_range(0, 1)); i_data_sel = 4'($urandom);
      i_data_addr = $urandom; i_data_wdata = $urandom;
      freq = fc && !fl;
      if (dc && !(freq && m_streak == STREAK)) begin
        owner = 2;
        m_streak = freq ? ((m_streak < STREAK) ? m_streak + 1 : STREAK) : 0;
      end else if (freq) begin
        owner = 1;
        m_streak = 0;
      end else begin
        owner = 0;
      end
      @(negedge i_clk);
      check("rnd_idle", {27'h0, resp()}, 32'h0);
      step();
      i_fetch_cyc = 1'b0; i_data_cyc = 1'b0; i_fetch_flush = 1'b0;
      if (owner != 0) begin
        lat = $urandom_range(1, 10);
        end_c = (lat <= TMO) ? lat : TMO;
        timed_out = (lat > TMO);
        flush_at = (owner == 1 && $urandom_range(0, 2) == 0) ? $urandom_range(1, end_c) : 0;
        dropped = (owner == 1) && (flush_at != 0);
        for (int c = 1; c <= end_c; c++) begin
          rd = $urandom;
          i_mem_ack = (c == lat); i_mem_rdata = rd; i_fetch_flush = (c == flush_at);
          @(negedge i_clk);
          if (c == 1) begin
            if (owner == 2) begin
              check("rnd_addr", o_mem_addr, i_data_addr);
              check("rnd_we_sel", {27'h0, o_mem_we, o_mem_sel}, {27'h0, i_data_we, i_data_sel});
              if (i_data_we) check("rnd_wdata", o_mem_wdata, i_data_wdata);
            end else begin
              check("rnd_addr", o_mem_addr, i_fetch_addr);
              check("rnd_we_sel", {27'h0, o_mem_we, o_mem_sel}, 32'hF);
            end
          end
          fack = (c == end_c) && owner == 1 && !timed_out && !dropped;
          ferr = (c == end_c) && owner == 1 && timed_out && !dropped;
          dack = (c == end_c) && owner == 2 && !timed_out;
          derr = (c == end_c) && owner == 2 && timed_out;
          check($sformatf("rnd%0d_busy%0d", it, c), {27'h0, resp()},
                {27'h0, 1'b1, fack, ferr, dack, derr});
          if (c == end_c) begin
            check("rnd_frdata", o_fetch_rdata, fack ? rd : 32'h0);
            check("rnd_drdata", o_data_rdata, dack ? rd : 32'h0);
          end
          step();
        end
        i_mem_ack = 1'b0; i_fetch_flush = 1'b0;
      end
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
